// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier:
// operand classes, per-stage control words, exponent bias and canonical quiet NaN.
package fp_mult_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Control carried alongside the data of stage 1
    typedef struct packed {
        logic valid;
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } s1_ctrl_t;

    // Control carried alongside the data of stage 2
    typedef struct packed {
        logic valid;
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } s2_ctrl_t;

    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

    // Sign 0, all-ones exponent, fraction MSB set; caller truncates to its word width
    function automatic logic [127:0] fp_qnan(input int exp_w, input int frac_w);
        logic [127:0] v;
        v = '0;
        for (int i = 32'sd0; i <= exp_w; i++) begin
            v[frac_w - 32'sd1 + i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Final-stage normalise/round/pack for fp_mult_pipe (combinational).
// FP_MULT_ROUND_EN selects round-to-nearest-even; otherwise the product is truncated.
module fp_mult_round
    import fp_mult_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W+1:0]        exp_in,
    input  logic [2*FRAC_W+1:0]     prod,
    input  logic                    sign,
    input  logic                    nan,
    input  logic                    inf,
    input  logic                    zero,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    invalid
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * FRAC_W + 2;
    localparam logic [W-1:0]  QNAN    = W'(fp_qnan(EXP_W, FRAC_W));
    localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic [XW-1:0]     norm_exp_s;
    logic [XW-1:0]     rnd_exp_s;
    logic [FRAC_W-1:0] frac_s;
    logic [FRAC_W-1:0] rnd_frac_s;
    logic              carry_s;

    // Normalise: a set top product bit means the significand is in [2,4)
    always_comb begin
        norm_exp_s = exp_in;
        frac_s     = prod[PW-3 -: FRAC_W];
        if (prod[PW-1]) begin
            norm_exp_s = exp_in + XW'(1'b1);
            frac_s     = prod[PW-2 -: FRAC_W];
        end else begin
            norm_exp_s = exp_in;
            frac_s     = prod[PW-3 -: FRAC_W];
        end
    end

`ifdef FP_MULT_ROUND_EN
    logic guard_s;
    logic sticky_s;
    logic round_up_s;

    // Guard and sticky come from the bits dropped by normalisation; ties go to even
    always_comb begin
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        if (prod[PW-1]) begin
            guard_s  = prod[FRAC_W];
            sticky_s = |prod[FRAC_W-1:0];
        end else begin
            guard_s  = prod[FRAC_W-1];
            sticky_s = |prod[FRAC_W-2:0];
        end
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        {carry_s, rnd_frac_s} = {1'b0, frac_s} + {{FRAC_W{1'b0}}, round_up_s};
    end
`else
    logic unused_low_s;
    assign unused_low_s = ^prod[FRAC_W-1:0];
    assign carry_s      = 1'b0;
    assign rnd_frac_s   = frac_s;
`endif

    assign rnd_exp_s = norm_exp_s + XW'(carry_s);

    // Special operands take priority over range checks on the finite product
    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        invalid   = 1'b0;
        if (nan) begin
            result  = QNAN;
            invalid = 1'b1;
        end else if (inf) begin
            result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (zero) begin
            result = {sign, {(EXP_W+FRAC_W){1'b0}}};
        end else if ($signed(rnd_exp_s) >= $signed(EXP_MAX)) begin
            result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            overflow = 1'b1;
        end else if ($signed(rnd_exp_s) <= $signed({XW{1'b0}})) begin
            result    = {sign, {(EXP_W+FRAC_W){1'b0}}};
            underflow = 1'b1;
        end else begin
            result = {sign, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; default build truncates.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    invalid
);
    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int XW   = EXP_W + 2;
    localparam int MW   = FRAC_W + 1;
    localparam int PW   = 2 * MW;
    localparam int BIAS = fp_bias(EXP_W);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] ex, input logic [FRAC_W-1:0] fr);
        fp_class_e c;
        if (ex == '0) begin
            c = ZERO;
        end else if (ex != '1) begin
            c = NORM;
        end else if (fr == '0) begin
            c = INF;
        end else begin
            c = NAN;
        end
        return c;
    endfunction

    logic           en_s;
    fp_class_e      cls_a_s;
    fp_class_e      cls_b_s;
    s1_ctrl_t       s1_ctrl_s;
    logic [XW-1:0]  s1_exp_s;

    s1_ctrl_t       s1_ctrl_r;
    logic [XW-1:0]  s1_exp_r;
    logic [MW-1:0]  s1_ma_r;
    logic [MW-1:0]  s1_mb_r;
    s2_ctrl_t       s2_ctrl_r;
    logic [XW-1:0]  s2_exp_r;
    logic [PW-1:0]  s2_prod_r;

    logic [W-1:0]   rnd_result_s;
    logic           rnd_ovf_s;
    logic           rnd_unf_s;
    logic           rnd_inv_s;

    logic           out_valid_r;
    logic [W-1:0]   result_r;
    logic           overflow_r;
    logic           underflow_r;
    logic           invalid_r;

    assign en_s      = !out_valid_r || out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign invalid   = invalid_r;

    // Stage 1 combinational: classify operands, resolve special cases, sum biased exponents
    always_comb begin
        cls_a_s         = classify(a[W-2 -: EXP_W], a[FRAC_W-1:0]);
        cls_b_s         = classify(b[W-2 -: EXP_W], b[FRAC_W-1:0]);
        s1_ctrl_s       = '0;
        s1_ctrl_s.valid = in_valid;
        s1_ctrl_s.sign  = a[W-1] ^ b[W-1];
        s1_ctrl_s.nan   = (cls_a_s == NAN) || (cls_b_s == NAN) ||
                          ((cls_a_s == INF) && (cls_b_s == ZERO)) ||
                          ((cls_a_s == ZERO) && (cls_b_s == INF));
        s1_ctrl_s.inf   = (cls_a_s == INF) || (cls_b_s == INF);
        s1_ctrl_s.zero  = (cls_a_s == ZERO) || (cls_b_s == ZERO);
        s1_exp_s        = XW'(a[W-2 -: EXP_W]) + XW'(b[W-2 -: EXP_W]) - XW'(BIAS);
    end

    fp_mult_round #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .exp_in    (s2_exp_r),
        .prod      (s2_prod_r),
        .sign      (s2_ctrl_r.sign),
        .nan       (s2_ctrl_r.nan),
        .inf       (s2_ctrl_r.inf),
        .zero      (s2_ctrl_r.zero),
        .result    (rnd_result_s),
        .overflow  (rnd_ovf_s),
        .underflow (rnd_unf_s),
        .invalid   (rnd_inv_s)
    );

    // Pipeline registers: every stage shifts on en_s and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ctrl_r   <= '0;
            s1_exp_r    <= '0;
            s1_ma_r     <= '0;
            s1_mb_r     <= '0;
            s2_ctrl_r   <= '0;
            s2_exp_r    <= '0;
            s2_prod_r   <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            invalid_r   <= 1'b0;
        end else if (en_s) begin
            s1_ctrl_r   <= s1_ctrl_s;
            s1_exp_r    <= s1_exp_s;
            s1_ma_r     <= {1'b1, a[FRAC_W-1:0]};
            s1_mb_r     <= {1'b1, b[FRAC_W-1:0]};
            s2_ctrl_r   <= s1_ctrl_r;
            s2_exp_r    <= s1_exp_r;
            s2_prod_r   <= PW'(s1_ma_r) * PW'(s1_mb_r);
            out_valid_r <= s2_ctrl_r.valid;
            // Bubbles leave the output word and flags at zero
            result_r    <= s2_ctrl_r.valid ? rnd_result_s : '0;
            overflow_r  <= s2_ctrl_r.valid & rnd_ovf_s;
            underflow_r <= s2_ctrl_r.valid & rnd_unf_s;
            invalid_r   <= s2_ctrl_r.valid & rnd_inv_s;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe (EXP_W=8, FRAC_W=23), scoreboard-based.
module tb_fp_mult_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    fp_mult_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [2:0]  flags;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_out    = 0;
    int          n_stall  = 0;
    int          out_base = 0;
    bit          lat_mode = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_flags;

    logic [31:0] stream_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] stream_r [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                  32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor: scoreboard, latency and stall-stability checks
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && out_valid) begin
                check_value("stall_result", 64'(result), 64'(held_res));
                check_value("stall_flags", 64'({overflow, underflow, invalid}), 64'(held_flags));
            end
            if (out_valid && !out_ready) begin
                check_value("stall_in_ready", 64'(in_ready), 64'd0);
                n_stall++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_out", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    n_out++;
                    check_value({mon_e.tag, "/result"}, 64'(result), 64'(mon_e.res));
                    check_value({mon_e.tag, "/flags"}, 64'({overflow, underflow, invalid}), 64'(mon_e.flags));
                    if (mon_e.chk_lat) begin
                        check_value({mon_e.tag, "/latency"}, 64'(cyc - mon_e.acc_cyc), 64'd3);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held_res   = result;
            held_flags = {overflow, underflow, invalid};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] res, input logic [2:0] fl);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a = va;
        b = vb;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.tag     = tag;
                e.res     = res;
                e.flags   = fl;
                e.acc_cyc = cyc;
                e.chk_lat = lat_mode;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_value({tag, "/accepted"}, 64'(done), 64'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        check_value({tag, "/drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset/out_valid", 64'(out_valid), 64'd0);
        check_value("reset/result", 64'(result), 64'd0);
        check_value("reset/flags", 64'({overflow, underflow, invalid}), 64'd0);
        check_value("reset/in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Directed vectors, back-to-back; flags are {overflow, underflow, invalid}
        send("mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
`ifdef FP_MULT_ROUND_EN
        send("round_rne",  32'h3FC00001, 32'h3FC00001, 32'h40100002, 3'b000);
        send("round_cry",  32'h3FC00003, 32'h3FAAAAA8, 32'h40000000, 3'b000);
`else
        send("round_trn",  32'h3FC00001, 32'h3FC00001, 32'h40100001, 3'b000);
        send("round_cry",  32'h3FC00003, 32'h3FAAAAA8, 32'h3FFFFFFF, 3'b000);
`endif
        send("ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
        send("unf",        32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
        send("inf_x_zero", 32'h7F800000, 32'h80000000, 32'h7FC00000, 3'b001);
        send("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
        send("nan_op",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001);
        send("zero_x_neg", 32'h00000000, 32'hC0000000, 32'h80000000, 3'b000);
        send("subnorm_in", 32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);
        send("neg_x_pos",  32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
        send("min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
        send("unf_edge",   32'h00800000, 32'h3F000000, 32'h00000000, 3'b010);
        send("max_finite", 32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 3'b000);
        send("ovf_edge",   32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100);
        send("neg_unf",    32'h80800000, 32'h00800000, 32'h80000000, 3'b010);
        idle();
        drain("directed");

        // Stream of 8 with a 5-cycle downstream stall in the middle
        lat_mode = 1'b0;
        n_stall  = 0;
        out_base = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send($sformatf("stream%0d", k), stream_a[k], 32'h40000000, stream_r[k], 3'b000);
                end
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stream");
        check_value("stream/count", 64'(n_out - out_base), 64'd8);
        check_value("stream/stall_cycles", 64'(n_stall), 64'd5);

        // Reset with three operations in flight
        lat_mode = 1'b1;
        send("rst_a", 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
        send("rst_b", 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
        send("rst_c", 32'h40400000, 32'h40000000, 32'h40C00000, 3'b000);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_value("mid_reset/out_valid", 64'(out_valid), 64'd0);
        check_value("mid_reset/result", 64'(result), 64'd0);
        check_value("mid_reset/in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        out_base  = n_out;
        send("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
        idle();
        drain("post_rst");
        repeat (6) @(posedge clk);
        check_value("post_rst/count", 64'(n_out - out_base), 64'd1);
        check_value("final/sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
